// File: rtl/gb_mmap_pkg.sv
// Shared types and limits for the memory-map fabric: channel index width and the
// in-flight load tag carried alongside the slave read latency.
package gb_mmap_pkg;

   localparam int MAX_NCH = 8;
   localparam int MAX_LATENCY = 4;
   localparam logic [7:0] DEFAULT_OPEN_BUS = 8'hFF;

   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   localparam int CHAN_W = clog2(MAX_NCH);

   typedef struct packed {
      logic              valid;
      logic              hit;
      logic [CHAN_W-1:0] chan_idx;
   } mmap_tag_t;

endpackage

// File: rtl/mmap_tag_pipe.sv
// Fixed-depth shift register of load tags; the tail lines up with the slave read data.
module mmap_tag_pipe
   import gb_mmap_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clock,
   input  logic      resetn,
   input  mmap_tag_t tag_in,
   output mmap_tag_t tag_out
);

   mmap_tag_t tag_p [DEPTH];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
      end else begin
         tag_p[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/mmap_fabric.sv
// N-channel memory-map fabric: priority decode, offset rebasing, optional request
// register, tagged read return with open-bus fill and a saturating miss counter.
module mmap_fabric
   import gb_mmap_pkg::*;
#(
   parameter int               NCH      = 4,
   parameter logic [NCH*16-1:0] STARTS  = '0,
   parameter logic [NCH*16-1:0] ENDS    = '0,
   parameter int               LATENCY  = 2,
   parameter int               REG_REQ  = 0,
   parameter logic [7:0]       OPEN_BUS = DEFAULT_OPEN_BUS
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [15:0]       m_address,
   input  logic [7:0]        m_indata,
   input  logic              m_load,
   input  logic              m_store,
   output logic [7:0]        m_outdata,
   output logic              m_valid,
   output logic              m_miss,
   output logic [7:0]        miss_count,
   output logic [NCH*16-1:0] address,
   output logic [NCH*8-1:0]  indata,
   input  logic [NCH*8-1:0]  outdata,
   output logic [NCH-1:0]    load,
   output logic [NCH-1:0]    store
);

   localparam int DEPTH = LATENCY + REG_REQ;

   logic              sel_hit;
   logic [CHAN_W-1:0] sel_idx;
   logic [15:0]       sel_off;
   logic              ld_acc;
   logic              miss_req;
   logic [NCH*16-1:0] addr_c;
   logic [NCH*8-1:0]  indata_c;
   logic [NCH-1:0]    load_c;
   logic [NCH-1:0]    store_c;
   mmap_tag_t         tag_in;
   mmap_tag_t         tag_tail;

   // Descending scan so the lowest-index matching region is the one left standing.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      sel_off = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (m_address >= STARTS[i*16 +: 16] && m_address <= ENDS[i*16 +: 16]) begin
            sel_hit = 1'b1;
            sel_idx = CHAN_W'(i);
            sel_off = m_address - STARTS[i*16 +: 16];
         end
      end
   end

   // A simultaneous load and store is a store; the load gets no response.
   assign ld_acc   = m_load & ~m_store;
   assign miss_req = ~sel_hit & (m_load | m_store);

   always_comb begin
      addr_c   = '0;
      indata_c = '0;
      load_c   = '0;
      store_c  = '0;
      if (sel_hit) begin
         addr_c[int'(sel_idx)*16 +: 16] = sel_off;
         indata_c[int'(sel_idx)*8 +: 8] = m_indata;
         load_c[sel_idx]                = ld_acc;
         store_c[sel_idx]               = m_store;
      end
   end

   // Slave request boundary: either registered (one extra cycle) or pass-through.
   if (REG_REQ != 0) begin : g_req_reg
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            address <= '0;
            indata  <= '0;
            load    <= '0;
            store   <= '0;
         end else begin
            address <= addr_c;
            indata  <= indata_c;
            load    <= load_c;
            store   <= store_c;
         end
      end
   end else begin : g_req_comb
      always_comb begin
         address = resetn ? addr_c   : '0;
         indata  = resetn ? indata_c : '0;
         load    = resetn ? load_c   : '0;
         store   = resetn ? store_c  : '0;
      end
   end

   assign tag_in = '{valid: ld_acc, hit: sel_hit, chan_idx: sel_idx};

   mmap_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
      .clock   (clock),
      .resetn  (resetn),
      .tag_in  (tag_in),
      .tag_out (tag_tail)
   );

   // Response stage: tag tail selects the returning channel or the open-bus value.
   always_comb begin
      m_valid   = tag_tail.valid;
      m_outdata = '0;
      if (tag_tail.valid) begin
         m_outdata = tag_tail.hit ? outdata[int'(tag_tail.chan_idx)*8 +: 8] : OPEN_BUS;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_miss     <= 1'b0;
         miss_count <= '0;
      end else begin
         m_miss <= miss_req;
         if (miss_req && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
      end
   end

endmodule

// File: doc/mmap_fabric.md
# mmap_fabric

Parametrised N-channel memory-map fabric between the CPU bus and up to NCH peripheral or memory regions. It is the successor to the single-region map/remap stages. It decodes one master request to at most one channel by priority and rebases the address to the region offset. A tag pipeline tracks every in-flight load, so it returns tagged read data with an explicit valid strobe, an open-bus value on unmapped reads, and a miss pulse and counter for unmapped accesses.

## Interface
Parameters:
- NCH, 4: number of channels, 1..8.
- STARTS, 0: packed NCH×16 region start addresses; channel i is at [i*16 +: 16].
- ENDS, 0: packed NCH×16 inclusive region end addresses, same packing; END ≥ START per channel.
- LATENCY, 2: slave read latency in cycles, from channel load to valid outdata, 1..4.
- REG_REQ, 0: 1 inserts a request register stage on the slave side; total read latency becomes LATENCY+1.
- OPEN_BUS, 8'hFF: data returned for an unmapped load.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m_address  in  16  master address.
- m_indata  in  8  master write data.
- m_load  in  1  master read request, one cycle per access.
- m_store  in  1  master write request, one cycle per access.
- m_outdata  out  8  read data; 0 whenever m_valid=0.
- m_valid  out  1  read data valid, one cycle per accepted load.
- m_miss  out  1  one-cycle pulse after an unmapped load or store.
- miss_count  out  8  saturating count of unmapped accesses.
- address  out  NCH×16  per-channel offset address (m_address − START).
- indata  out  NCH×8  per-channel write data.
- outdata  in  NCH×8  per-channel read data.
- load  out  NCH  per-channel read strobe.
- store  out  NCH  per-channel write strobe.

## Operation
- Decode: hit[i] = STARTS[i] ≤ m_address ≤ ENDS[i]. The lowest-index hit wins, so overlapping regions resolve by index. Exactly one channel or none is selected.
- Selected channel: address = m_address − STARTS[i] (16-bit, no wrap because m_address ≥ START), indata = m_indata, and load and store mirror the master strobes.
- Unselected channels: address, indata, load and store are all 0.
- m_load and m_store asserted together: treated as a store only. The load is suppressed and no response is generated.
- Tag pipeline: each accepted load pushes {valid, hit, chan_idx} into a shift register of depth LATENCY+REG_REQ. A store or idle cycle pushes valid=0.
- Pipeline tail with valid=1 and hit=1: m_valid=1, m_outdata = outdata[chan_idx].
- Pipeline tail with valid=1 and hit=0: m_valid=1, m_outdata = OPEN_BUS.
- Unmapped load or store: m_miss=1 on the next cycle; miss_count increments and saturates at 8'hFF.
- Requests are never stalled. Back-to-back loads every cycle produce back-to-back responses in order.

## Timing
- Reset values: m_valid=0, m_outdata=0, m_miss=0, miss_count=0, tag pipeline cleared. With REG_REQ=1, the registered slave outputs also reset to 0.
- REG_REQ=0: slave outputs are combinational from the master inputs in the same cycle.
- REG_REQ=1: slave outputs are registered, one cycle after the master request.
- Load at cycle t: m_valid and data appear at t+LATENCY+REG_REQ. m_outdata is combinational from outdata of the tagged channel.
- m_miss: asserted at t+1 for a miss at t, independent of LATENCY.
- Reset mid-operation: all in-flight tags are discarded and no m_valid is produced for them. Slave strobes drop immediately.
- miss_count at 8'hFF stays at 8'hFF. Misses at or after saturation still pulse m_miss.

## Structure
- Shared package gb_mmap_pkg holds:
  - MAX_NCH=8, MAX_LATENCY=4, DEFAULT_OPEN_BUS=8'hFF.
  - Function clog2 for the chan_idx width.
  - Tag struct/typedef {valid, hit, chan_idx}.
- One sub-module, mmap_tag_pipe: parametrised depth shift register of tags with asynchronous clear.
- Decode, offset subtraction and the response mux stay in mmap_fabric.

## Test plan
Common configuration: NCH=3; STARTS={0x0000,0x8000,0xFF80}; ENDS={0x7FFF,0x9FFF,0xFFFE}; LATENCY=2; REG_REQ=0.
- Load 0x8010 at t, slave 1 returns 0x5A → at t: load[1]=1, address[1]=0x0010; at t+2: m_valid=1, m_outdata=0x5A.
- Store 0xFF85 with data 0x33 → store[2]=1, address[2]=0x0005, indata[2]=0x33; other channels all 0; m_valid stays 0.
- Load 0xA000 (unmapped) at t → m_miss=1 at t+1; m_valid=1, m_outdata=0xFF at t+2; miss_count=1.
- Loads at 0x0001, 0x8001, 0xFF81 on consecutive cycles → three consecutive m_valid cycles carrying each channel's data in order. Repeat with REG_REQ=1: same result, shifted one cycle later.
- 300 unmapped stores → miss_count saturates at 0xFF; m_miss pulses for every access.
- Load at t, resetn low at t+1 → no m_valid after reset; all outputs 0; miss_count=0.
